axi_lite_wr_regs: RTL and testbench
===================================

# axi_lite_wr_regs

Write-only AXI4-Lite slave consuming the AW/W/B channels driven by the bench or PS master, and terminating them in a bank of control registers that configure the U-Net accelerator core. It accepts the write address and write data independently, in either order. It byte-merges the write into the addressed register under `wstrb`, then returns a B response. Register contents, per-register write strobes and a self-clearing start pulse are exported to the core.

## Interface
Parameters:
- `DATA_W`, 32, AXI data width; fixed at 32.
- `ADDR_W`, 6, AXI byte address width; word index is `awaddr[ADDR_W-1:2]`.
- `NUM_RW`, 14, number of writable registers (indices 0..NUM_RW-1); the remaining indices up to 15 are read-only status slots.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst_i`  in  1  synchronous, active-high reset.
- `awaddr`  in  ADDR_W  write address.
- `awprot`  in  3  accepted and ignored.
- `awvalid`  in  1  AW valid.
- `awready`  out  1  AW ready.
- `wdata`  in  DATA_W  write data.
- `wstrb`  in  DATA_W/8  byte enables.
- `wvalid`  in  1  W valid.
- `wready`  out  1  W ready.
- `bresp`  out  2  00 OKAY, 10 SLVERR.
- `bvalid`  out  1  B valid.
- `bready`  in  1  B ready.
- `regs_o`  out  NUM_RW*DATA_W  register bank, reg i at `[i*32 +: 32]`.
- `wr_strobe_o`  out  NUM_RW  one-cycle pulse, bit i when reg i was updated.
- `start_o`  out  1  one-cycle accelerator start pulse.

## Operation
- States: IDLE, WRITE, RESP.
- Holding flags `aw_held` and `w_held` each capture their channel payload on handshake (valid && ready at posedge).
- `awready = (state==IDLE) && !aw_held`.
- `wready = (state==IDLE) && !w_held`.
- IDLE -> WRITE at the edge after which both flags are set. This covers both channels arriving in the same cycle, and either order with any gap between them.
- WRITE (one cycle), performed at the edge leaving WRITE:
  - Word index `idx = aw_addr_q[5:2]`; `awaddr[1:0]` is ignored.
  - If `idx < NUM_RW`: for each byte b with `wstrb_q[b]=1`, `reg[idx][8b+7:8b] <= wdata_q[8b+7:8b]`; `bresp <= OKAY`; `wr_strobe_o[idx] <= 1`.
  - If `idx >= NUM_RW`: no register changes; `bresp <= SLVERR`; no strobe.
  - A write with `wstrb == 0` to a writable index returns OKAY and leaves the data unchanged. The strobe still pulses.
  - Start: if `idx==0`, `wstrb_q[0]=1` and `wdata_q[0]=1`, then `start_o <= 1`. Reg 0 bit 0 is always stored as 0 (self-clearing). The other bits of reg 0 follow the normal merge.
  - Next state is RESP with `bvalid <= 1`.
- RESP: `bvalid` and `bresp` are held stable until `bready`. On the handshake edge: `bvalid <= 0`, both flags cleared, state -> IDLE.
- No new AW/W is accepted outside IDLE, so at most one transaction is outstanding.

## Timing
- Reset values:
  - `awready=1`, `wready=1`, `bvalid=0`, `bresp=00`.
  - All registers 0, `wr_strobe_o=0`, `start_o=0`.
  - State IDLE, flags clear.
- Reset mid-transaction drops held AW/W and any pending B without a response. Reset has priority over every other update in the same cycle.
- Latency, both channels handshaking at edge k:
  - WRITE during cycle k..k+1.
  - At edge k+1: `regs_o` updates, `bvalid=1`, `wr_strobe_o`/`start_o` high for exactly one cycle.
  - With `bready=1`, `bvalid` falls at edge k+2, and `awready`/`wready` are high again from k+2.
  - Peak throughput is one write per 3 cycles.
- Skewed arrival: the second-arriving channel's handshake edge plays the role of edge k.
- `awready` and `wready` depend on registered state only, with no combinational path from `*valid`. `bvalid` is a register output.
- `wr_strobe_o` and `start_o` are registered and deassert on the next edge unconditionally.

## Structure
- Shared package `axi_lite_pkg`:
  - `AXI_DATA_W=32`, `AXI_ADDR_W=6`, `AXI_STRB_W=4`.
  - `BRESP_OKAY=2'b00`, `BRESP_SLVERR=2'b10`.
  - Write FSM state enum `wr_state_e {WR_IDLE, WR_WRITE, WR_RESP}`.
  - Function `strb_merge(old, data, strb)` returning the byte-merged word.
  - Register index constants `REG_CTRL=0` and `CTRL_START_BIT=0`.
- No sub-module required. The FSM, holding registers and bank sit in one module.

## Test plan
- AW and W in same cycle: addr 0x04, data 0xDEADBEEF, strb 0xF -> reg1=0xDEADBEEF at k+1; `bvalid=1` with `bresp=00` at k+1; `wr_strobe_o=14'h0002` for one cycle.
- W three cycles before AW: addr 0x08, data 0x12345678, strb 0x5 over reg2=0xFFFFFFFF -> reg2=0xFF34FF78; `awready`/`wready` low until B completes.
- Start pulse: addr 0x00, data 0x00000103, strb 0x3 -> `start_o` high exactly one cycle; reg0=0x00000102.
- Read-only slot: addr 0x38 (idx 14), data 0xAAAAAAAA -> `bresp=10`; all regs unchanged; no strobe.
- B backpressure and reset: hold `bready=0` for 5 cycles -> `bvalid` and `bresp` stable, `awready=0`; assert `rst_i` during RESP -> next cycle `bvalid=0`, all regs 0, `awready=1`.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg
//   Shared constants, the write FSM state type and the byte-merge helper used by
//   the AXI4-Lite control register slave.
package axi_lite_pkg;

   localparam int unsigned AXI_DATA_W = 32;
   localparam int unsigned AXI_ADDR_W = 6;
   localparam int unsigned AXI_STRB_W = 4;

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;

   // Register 0 is the control register; bit 0 of it is the self-clearing start bit.
   localparam int unsigned REG_CTRL       = 0;
   localparam int unsigned CTRL_START_BIT = 0;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_WRITE = 2'd1,
      WR_RESP  = 2'd2
   } wr_state_e;

   // Replace each byte of old whose strobe bit is set with the matching byte of data.
   function automatic logic [AXI_DATA_W-1:0] strb_merge(input logic [AXI_DATA_W-1:0] old,
                                                        input logic [AXI_DATA_W-1:0] data,
                                                        input logic [AXI_STRB_W-1:0] strb);
      logic [AXI_DATA_W-1:0] res;
      for (int b = 0; b < int'(AXI_STRB_W); b++) begin
         res[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_lite_wr_regs.sv
// axi_lite_wr_regs
//   Write-only AXI4-Lite slave terminating AW/W/B into a bank of control registers
//   for the accelerator core. AW and W are captured independently in either order,
//   merged into the addressed register under wstrb, then answered on B.
// Ports
//   clk, rst_i                 clock, synchronous active-high reset
//   awaddr/awprot/awvalid/awready   write address channel (awprot ignored)
//   wdata/wstrb/wvalid/wready        write data channel
//   bresp/bvalid/bready              write response channel
//   regs_o                     register bank, reg i at [i*32 +: 32]
//   wr_strobe_o                one-cycle pulse per updated register
//   start_o                    one-cycle accelerator start pulse
module axi_lite_wr_regs
   import axi_lite_pkg::*;
#(
   parameter int unsigned DATA_W = AXI_DATA_W,
   parameter int unsigned ADDR_W = AXI_ADDR_W,
   parameter int unsigned NUM_RW = 14
) (
   input  logic                     clk,
   input  logic                     rst_i,
   input  logic [ADDR_W-1:0]        awaddr,
   input  logic [2:0]               awprot,
   input  logic                     awvalid,
   output logic                     awready,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [DATA_W/8-1:0]      wstrb,
   input  logic                     wvalid,
   output logic                     wready,
   output logic [1:0]               bresp,
   output logic                     bvalid,
   input  logic                     bready,
   output logic [NUM_RW*DATA_W-1:0] regs_o,
   output logic [NUM_RW-1:0]        wr_strobe_o,
   output logic                     start_o
);

   wr_state_e                 state_q;
   logic                      aw_held_q, w_held_q;
   logic [ADDR_W-3:0]         aw_idx_q;
   logic [DATA_W-1:0]         wdata_q;
   logic [DATA_W/8-1:0]       wstrb_q;
   logic [NUM_RW*DATA_W-1:0]  regs_q;
   logic [1:0]                bresp_q;
   logic                      bvalid_q;
   logic [NUM_RW-1:0]         strobe_q;
   logic                      start_q;

   logic                      aw_hs, w_hs;
   logic                      idx_writable, idx_is_ctrl;
   logic [DATA_W-1:0]         cur_word, merged;

   // Byte offset and protection carry no meaning for this register bank.
   logic unused_sig;
   assign unused_sig = ^{awprot, awaddr[1:0]};

   // Ready is a function of registered state only.
   assign awready = (state_q == WR_IDLE) && !aw_held_q;
   assign wready  = (state_q == WR_IDLE) && !w_held_q;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;

   assign idx_writable = (32'(aw_idx_q) < 32'(NUM_RW));
   assign idx_is_ctrl  = (32'(aw_idx_q) == REG_CTRL);

   always_comb begin
      cur_word = '0;
      for (int i = 0; i < int'(NUM_RW); i++) begin
         if (32'(aw_idx_q) == 32'(i)) cur_word = regs_q[i*DATA_W +: DATA_W];
      end
      merged = strb_merge(cur_word, wdata_q, wstrb_q);
      // The start bit never reads back as set; it only produces the start_o pulse.
      if (idx_is_ctrl) merged[CTRL_START_BIT] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q   <= WR_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         regs_q    <= '0;
         bresp_q   <= BRESP_OKAY;
         bvalid_q  <= 1'b0;
         strobe_q  <= '0;
         start_q   <= 1'b0;
      end else begin
         strobe_q <= '0;
         start_q  <= 1'b0;
         case (state_q)
            WR_IDLE: begin
               if (aw_hs) begin
                  aw_held_q <= 1'b1;
                  aw_idx_q  <= awaddr[ADDR_W-1:2];
               end
               if (w_hs) begin
                  w_held_q <= 1'b1;
                  wdata_q  <= wdata;
                  wstrb_q  <= wstrb;
               end
               if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) state_q <= WR_WRITE;
            end
            WR_WRITE: begin
               if (idx_writable) begin
                  for (int i = 0; i < int'(NUM_RW); i++) begin
                     if (32'(aw_idx_q) == 32'(i)) begin
                        regs_q[i*DATA_W +: DATA_W] <= merged;
                        strobe_q[i]                <= 1'b1;
                     end
                  end
                  bresp_q <= BRESP_OKAY;
               end else begin
                  bresp_q <= BRESP_SLVERR;
               end
               if (idx_is_ctrl && wstrb_q[CTRL_START_BIT/8] && wdata_q[CTRL_START_BIT]) begin
                  start_q <= 1'b1;
               end
               bvalid_q <= 1'b1;
               state_q  <= WR_RESP;
            end
            WR_RESP: begin
               if (bready) begin
                  bvalid_q  <= 1'b0;
                  aw_held_q <= 1'b0;
                  w_held_q  <= 1'b0;
                  state_q   <= WR_IDLE;
               end
            end
            default: state_q <= WR_IDLE;
         endcase
      end
   end

   assign bresp       = bresp_q;
   assign bvalid      = bvalid_q;
   assign regs_o      = regs_q;
   assign wr_strobe_o = strobe_q;
   assign start_o     = start_q;

endmodule

// File: tb/tb_axi_lite_wr_regs.sv
// tb_axi_lite_wr_regs
//   Scoreboard bench: each issued write pushes its expected B response, pulses and
//   register bank image; a monitor pops and compares when bvalid first rises.
module tb_axi_lite_wr_regs;
   import axi_lite_pkg::*;

   localparam int NRW = 14;
   localparam int BW  = NRW * 32;

   logic            clk = 1'b0;
   logic            rst_i;
   logic [5:0]      awaddr;
   logic [2:0]      awprot;
   logic            awvalid, awready;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wvalid, wready;
   logic [1:0]      bresp;
   logic            bvalid, bready;
   logic [BW-1:0]   regs_o;
   logic [NRW-1:0]  wr_strobe_o;
   logic            start_o;

   axi_lite_wr_regs #(.DATA_W(32), .ADDR_W(6), .NUM_RW(NRW)) dut (
      .clk(clk), .rst_i(rst_i),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .regs_o(regs_o), .wr_strobe_o(wr_strobe_o), .start_o(start_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]     resp;
      logic [NRW-1:0] strobe;
      logic           start;
      logic [BW-1:0]  regs;
      int             due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model[NRW];
   int          errors = 0;
   int          checks = 0;
   int          ha_g, hw_g;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout/unexpected expected handshake", name);
   endtask

   function automatic logic [BW-1:0] flat_model();
      logic [BW-1:0] r;
      for (int i = 0; i < NRW; i++) r[i*32 +: 32] = model[i];
      return r;
   endfunction

   task automatic drive_aw(input logic [5:0] a, input int lead);
      ha_g = -1;
      if (lead > 0) begin
         repeat (lead) @(posedge clk);
         #1;
      end
      awaddr  = a;
      awprot  = 3'b010;
      awvalid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (awready) begin
            @(posedge clk);
            #1;
            ha_g = cyc;
            break;
         end
      end
      awvalid = 1'b0;
      if (ha_g < 0) fail_now("aw_handshake");
   endtask

   task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int lead);
      hw_g = -1;
      if (lead > 0) begin
         repeat (lead) @(posedge clk);
         #1;
      end
      wdata  = d;
      wstrb  = s;
      wvalid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (wready) begin
            @(posedge clk);
            #1;
            hw_g = cyc;
            break;
         end
      end
      wvalid = 1'b0;
      if (hw_g < 0) fail_now("w_handshake");
   endtask

   // exp_val is the hand-computed new value of the addressed register (OKAY cases).
   task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_lead, input int w_lead, input logic [1:0] exp_resp,
                           input logic [31:0] exp_val, input logic [NRW-1:0] exp_strobe,
                           input logic exp_start);
      exp_t e;
      fork
         drive_aw(a, aw_lead);
         drive_w(d, s, w_lead);
      join
      if (exp_resp == BRESP_OKAY) model[int'(a[5:2])] = exp_val;
      e.resp   = exp_resp;
      e.strobe = exp_strobe;
      e.start  = exp_start;
      e.regs   = flat_model();
      e.due    = ((ha_g > hw_g) ? ha_g : hw_g) + 1;
      sb.push_back(e);
   endtask

   task automatic wait_b();
      bit done = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bvalid && bready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
            break;
         end
      end
      if (!done) fail_now("b_handshake");
   endtask

   // Monitor
   initial begin
      bit         prev_bv = 1'b0, prev_hs = 1'b0, saw_rst = 1'b0, pulse_chk = 1'b0;
      logic [1:0] held = 2'b00;
      exp_t       e;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            saw_rst   = 1'b1;
            prev_bv   = 1'b0;
            prev_hs   = 1'b0;
            pulse_chk = 1'b0;
            continue;
         end
         if (saw_rst) begin
            saw_rst = 1'b0;
            check("rst_bvalid", BW'(bvalid), BW'(0));
            check("rst_bresp", BW'(bresp), BW'(0));
            check("rst_ready", BW'({awready, wready}), BW'(2'b11));
            check("rst_regs", regs_o, BW'(0));
            check("rst_pulses", BW'({wr_strobe_o, start_o}), BW'(0));
         end
         if (prev_hs) check("after_b_hs", BW'({bvalid, awready, wready}), BW'(3'b011));
         if (bvalid && !prev_bv) begin
            if (sb.size() == 0) begin
               fail_now("b_without_request");
            end else begin
               e = sb.pop_front();
               check("b_latency", BW'(cyc), BW'(e.due));
               check("bresp", BW'(bresp), BW'(e.resp));
               check("wr_strobe", BW'(wr_strobe_o), BW'(e.strobe));
               check("start", BW'(start_o), BW'(e.start));
               check("regs", regs_o, e.regs);
               check("ready_in_resp", BW'({awready, wready}), BW'(0));
            end
            held      = bresp;
            pulse_chk = 1'b1;
         end else begin
            if (pulse_chk) check("pulse_width", BW'({wr_strobe_o, start_o}), BW'(0));
            else if (wr_strobe_o != '0 || start_o)
               check("stray_pulse", BW'({wr_strobe_o, start_o}), BW'(0));
            pulse_chk = 1'b0;
            if (bvalid) check("b_hold", BW'({bresp, awready, wready}), BW'({held, 2'b00}));
         end
         prev_bv = bvalid;
         prev_hs = bvalid && bready;
      end
   end

   // Stimulus
   initial begin
      bit seen;
      rst_i   = 1'b1;
      awaddr  = '0;
      awprot  = '0;
      awvalid = 1'b0;
      wdata   = '0;
      wstrb   = '0;
      wvalid  = 1'b0;
      bready  = 1'b1;
      for (int i = 0; i < NRW; i++) model[i] = '0;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Same-cycle AW/W
      do_write(6'h04, 32'hDEADBEEF, 4'hF, 0, 0, BRESP_OKAY, 32'hDEADBEEF, 14'h0002, 1'b0);
      wait_b();
      do_write(6'h08, 32'hFFFFFFFF, 4'hF, 0, 0, BRESP_OKAY, 32'hFFFFFFFF, 14'h0004, 1'b0);
      wait_b();
      // W three cycles ahead of AW, partial strobe
      do_write(6'h08, 32'h12345678, 4'h5, 3, 0, BRESP_OKAY, 32'hFF34FF78, 14'h0004, 1'b0);
      wait_b();
      // Start pulse; bit 0 self-clears
      do_write(6'h00, 32'h00000103, 4'h3, 0, 0, BRESP_OKAY, 32'h00000102, 14'h0001, 1'b1);
      wait_b();
      // Read-only slots
      do_write(6'h38, 32'hAAAAAAAA, 4'hF, 0, 0, BRESP_SLVERR, 32'h0, 14'h0000, 1'b0);
      wait_b();
      do_write(6'h3C, 32'h55AA55AA, 4'hF, 0, 1, BRESP_SLVERR, 32'h0, 14'h0000, 1'b0);
      wait_b();
      // Zero strobe: OKAY, data unchanged, strobe still pulses
      do_write(6'h0C, 32'h55555555, 4'h0, 0, 0, BRESP_OKAY, 32'h00000000, 14'h0008, 1'b0);
      wait_b();
      // AW two cycles ahead, low address bits ignored, last writable index
      do_write(6'h35, 32'hCAFEF00D, 4'hC, 0, 2, BRESP_OKAY, 32'hCAFE0000, 14'h2000, 1'b0);
      wait_b();
      // Start bit data set but its byte not strobed: no start
      do_write(6'h00, 32'h00000001, 4'h2, 0, 0, BRESP_OKAY, 32'h00000002, 14'h0001, 1'b0);
      wait_b();

      // Backpressure then reset while in RESP
      bready = 1'b0;
      do_write(6'h10, 32'h00000011, 4'hF, 0, 0, BRESP_OKAY, 32'h00000011, 14'h0010, 1'b0);
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bvalid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) fail_now("bvalid_rise");
      repeat (5) @(posedge clk);
      #1 rst_i = 1'b1;
      for (int i = 0; i < NRW; i++) model[i] = '0;
      @(posedge clk);
      #1 rst_i = 1'b0;
      bready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Normal operation after reset
      do_write(6'h04, 32'h0000005A, 4'h1, 0, 0, BRESP_OKAY, 32'h0000005A, 14'h0002, 1'b0);
      wait_b();
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", BW'(sb.size()), BW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
